// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory read port, decode handshake and redirect.
// The master modport is the fetch controller side, slave is the memory/decode/branch side.
interface fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr, imem_rmask, dec_valid, dec_inst, dec_pc,
        input  imem_rdata, imem_resp, dec_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, imem_rmask, dec_valid, dec_inst, dec_pc,
        output imem_rdata, imem_resp, dec_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// RV32I fetch controller: owns the fetch PC, issues imem reads, queues in-order responses for decode.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input logic        clk,
    input logic        rst,
    fetch_ctrl_if.master bus
);
    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          rst_q;

    logic          q_nonempty;
    logic          resp_keep;
    logic          bypass;
    logic          bypass_taken;
    logic          pop;
    logic          pop_q;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;
    logic          dec_valid_c;
    logic [31:0]   dec_inst_c;
    logic [31:0]   dec_pc_c;

    assign q_nonempty = (count != '0);
    assign resp_keep  = !rst && bus.imem_resp && !bus.redirect && (drop_cnt == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass       = !q_nonempty && resp_keep;
    assign bypass_taken = bypass && bus.dec_ready;
`else
    assign bypass       = 1'b0;
    assign bypass_taken = 1'b0;
`endif

    always_comb begin
        dec_valid_c = 1'b0;
        dec_inst_c  = NOP;
        dec_pc_c    = rst ? RESET_PC : resp_pc;
        if (!rst && q_nonempty) begin
            dec_valid_c = 1'b1;
            dec_inst_c  = q_inst[head];
            dec_pc_c    = q_pc[head];
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            dec_valid_c = 1'b1;
            dec_inst_c  = bus.imem_rdata;
            dec_pc_c    = resp_pc;
        end
`endif
    end

    assign bus.dec_valid = dec_valid_c;
    assign bus.dec_inst  = dec_inst_c;
    assign bus.dec_pc    = dec_pc_c;

    // A bypassed response is still counted in outstanding, so occ cannot underflow.
    assign pop   = dec_valid_c && bus.dec_ready;
    assign pop_q = !rst && q_nonempty && bus.dec_ready;
    assign push  = resp_keep && !bypass_taken;
    assign occ   = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);
    assign issue = !rst && !rst_q && !bus.redirect && (occ < (CW+1)'(DEPTH));

    assign bus.imem_addr  = rst ? RESET_PC : pc;
    assign bus.imem_rmask = issue ? 4'hF : 4'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rst_q       <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (bus.redirect) begin
                pc          <= bus.redirect_pc;
                resp_pc     <= bus.redirect_pc;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                outstanding <= outstanding - CW'(bus.imem_resp);
                // outstanding already includes earlier pending drops, so it replaces drop_cnt.
                drop_cnt    <= outstanding - CW'(bus.imem_resp);
            end else begin
                if (issue)
                    pc <= pc + 32'd4;
                outstanding <= outstanding + CW'(issue) - CW'(bus.imem_resp);
                if (bus.imem_resp) begin
                    if (drop_cnt != '0)
                        drop_cnt <= drop_cnt - CW'(1);
                    else
                        resp_pc <= resp_pc + 32'd4;
                end
                if (push)
                    tail <= tail + AW'(1);
                if (pop_q)
                    head <= head + AW'(1);
                count <= count + CW'(push) - CW'(pop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= bus.imem_rdata;
            q_pc[tail]   <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle in-order instruction memory model.
module tb_fetch_ctrl;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1eceb000;
    localparam logic [31:0] NOP      = 32'h00000013;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_iss = -1;
    int first_dec = -1;
    bit resp_en = 1'b0;

    logic [31:0] iss_q   [$];
    logic [31:0] pend_q  [$];
    logic [31:0] dpc_q   [$];
    logic [31:0] dinst_q [$];

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'ha5c30013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Observe at negedge, then drive next-cycle inputs 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.imem_rmask == 4'hF) begin
            iss_q.push_back(bus.imem_addr);
            pend_q.push_back(bus.imem_addr);
            if (first_iss < 0) first_iss = cyc;
        end
        if (bus.dec_valid && bus.dec_ready) begin
            dpc_q.push_back(bus.dec_pc);
            dinst_q.push_back(bus.dec_inst);
            if (first_dec < 0) first_dec = cyc;
        end
        @(posedge clk);
        #1;
        bus.imem_resp = 1'b0;
        bus.redirect  = 1'b0;
        if (resp_en && pend_q.size() > 0) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = mem_data(pend_q.pop_front());
        end
    endtask

    task automatic force_resp();
        if (pend_q.size() > 0) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = mem_data(pend_q.pop_front());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        resp_en = 1'b0;
        bus.imem_resp = 1'b0;
        bus.redirect = 1'b0;
        bus.dec_ready = 1'b0;
        step();
        step();
        iss_q.delete();
        pend_q.delete();
        dpc_q.delete();
        dinst_q.delete();
        first_iss = -1;
        first_dec = -1;
        cyc = 0;
        rst = 1'b0;
    endtask

    task automatic wait_issued(input int n);
        int k = 0;
        while (iss_q.size() < n && k < 50) begin
            step();
            k++;
        end
        check("wait_issued", 32'(iss_q.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_rdata  = 32'h0;
        bus.imem_resp   = 1'b0;
        bus.dec_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset values, checked while rst is still high and then in the first cycle after.
        rst = 1'b1;
        step();
        step();
        check("rst_rmask", 32'(bus.imem_rmask), 32'h0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_valid", 32'(bus.dec_valid), 32'h0);
        check("rst_inst", bus.dec_inst, NOP);
        check("rst_pc", bus.dec_pc, RESET_PC);
        rst = 1'b0;
        #1;
        check("post_rst_rmask", 32'(bus.imem_rmask), 32'h0);
        check("post_rst_addr", bus.imem_addr, RESET_PC);
        check("post_rst_valid", 32'(bus.dec_valid), 32'h0);

        // Streaming fetch with decode always ready.
        do_reset();
        bus.dec_ready = 1'b1;
        resp_en = 1'b1;
        repeat (14) step();
        check("t1_ndeliv_ge6", 32'(dpc_q.size() >= 6), 32'h1);
        for (int i = 0; i < 6; i++) begin
            check("t1_iss_addr", iss_q[i], RESET_PC + 32'(4 * i));
            check("t1_dec_pc", dpc_q[i], RESET_PC + 32'(4 * i));
            check("t1_dec_inst", dinst_q[i], mem_data(RESET_PC + 32'(4 * i)));
        end
        check("t1_latency", 32'(first_dec - first_iss), 32'(LAT));

        // Backpressure: queue fills to DEPTH, then one pop frees exactly one issue.
        do_reset();
        bus.dec_ready = 1'b0;
        resp_en = 1'b1;
        repeat (10) step();
        check("t2_nissue", 32'(iss_q.size()), 32'd4);
        check("t2_last_addr", iss_q[3], RESET_PC + 32'hc);
        check("t2_rmask_idle", 32'(bus.imem_rmask), 32'h0);
        check("t2_valid", 32'(bus.dec_valid), 32'h1);
        check("t2_head_inst", bus.dec_inst, mem_data(RESET_PC));
        check("t2_head_pc", bus.dec_pc, RESET_PC);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        repeat (4) step();
        check("t2_nissue_after", 32'(iss_q.size()), 32'd5);
        check("t2_new_addr", iss_q[4], RESET_PC + 32'h10);
        check("t2_ndeliv", 32'(dpc_q.size()), 32'd1);
        check("t2_head_pc2", bus.dec_pc, RESET_PC + 32'h4);

        // Redirect with 3 reads outstanding: all three are discarded.
        do_reset();
        bus.dec_ready = 1'b1;
        wait_issued(3);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h00001000;
        step();
        resp_en = 1'b1;
        repeat (12) step();
        check("t3_iss_new", iss_q[3], 32'h00001000);
        check("t3_dec_pc0", dpc_q[0], 32'h00001000);
        check("t3_dec_inst0", dinst_q[0], mem_data(32'h00001000));
        check("t3_dec_pc1", dpc_q[1], 32'h00001004);

        // Redirect coinciding with a response while 2 are outstanding: one more is dropped.
        do_reset();
        bus.dec_ready = 1'b1;
        wait_issued(2);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h00004000;
        force_resp();
        step();
        resp_en = 1'b1;
        repeat (10) step();
        check("t4_dec_pc0", dpc_q[0], 32'h00004000);
        check("t4_dec_inst0", dinst_q[0], mem_data(32'h00004000));
        check("t4_dec_pc1", dpc_q[1], 32'h00004004);
        check("t4_dec_inst1", dinst_q[1], mem_data(32'h00004004));

        // Back-to-back redirects with 2 in flight; only the second target reaches decode.
        do_reset();
        bus.dec_ready = 1'b1;
        wait_issued(2);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h00002000;
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h00003000;
        step();
        resp_en = 1'b1;
        repeat (10) step();
        check("t5_iss_new", iss_q[2], 32'h00003000);
        check("t5_dec_pc0", dpc_q[0], 32'h00003000);
        check("t5_dec_inst0", dinst_q[0], mem_data(32'h00003000));
        check("t5_dec_pc1", dpc_q[1], 32'h00003004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
